// File: rtl/rrd_pipe_pkg.sv
// Shared constants, slot record and branch-kill helper for the RRD -> EXE skid buffer.
package rrd_pipe_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned BR_W  = 20;
    localparam int unsigned UOP_W = 128;

    // One buffered uop together with its operands.
    typedef struct packed {
        logic             valid;
        logic [UOP_W-1:0] uop;
        logic [BR_W-1:0]  br_mask;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
    } rrd_slot_t;

    // True when any branch this uop depends on was mispredicted.
    function automatic logic br_killed(input logic [BR_W-1:0] mask,
                                       input logic [BR_W-1:0] mispredict);
        return |(mask & mispredict);
    endfunction

endpackage

// File: rtl/rrd_slot_update.sv
// Applies one cycle of branch resolution and kill to a single slot.
// Purely combinational; used for both stored slots and the incoming uop.
module rrd_slot_update
    import rrd_pipe_pkg::*;
(
    input  rrd_slot_t       cur,
    input  logic [BR_W-1:0] resolve_mask,
    input  logic [BR_W-1:0] mispredict_mask,
    input  logic            kill,
    output rrd_slot_t       upd
);

    // Clear resolved bits and gate valid with flush / mispredict; mispredict beats resolve.
    always_comb begin
        upd         = cur;
        upd.br_mask = cur.br_mask & ~resolve_mask;
        upd.valid   = cur.valid & ~kill & ~br_killed(cur.br_mask, mispredict_mask);
    end

endmodule

// File: rtl/rrd_exe_skid_buffer.sv
// Two-entry skid buffer between register-read and the integer execution unit.
// Head lives in slot 0; io_in_ready depends only on registered state.
// Optional perf counters are enabled by defining RRD_EXE_SKID_BUFFER_PERF_EN.
module rrd_exe_skid_buffer
    import rrd_pipe_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [UOP_W-1:0] io_in_uop,
    input  logic [BR_W-1:0]  io_in_br_mask,
    input  logic [XLEN-1:0]  io_in_rs1_data,
    input  logic [XLEN-1:0]  io_in_rs2_data,
    input  logic [BR_W-1:0]  io_brupdate_resolve_mask,
    input  logic [BR_W-1:0]  io_brupdate_mispredict_mask,
    input  logic             io_kill,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [UOP_W-1:0] io_out_uop,
    output logic [BR_W-1:0]  io_out_br_mask,
    output logic [XLEN-1:0]  io_out_rs1_data,
`ifdef RRD_EXE_SKID_BUFFER_PERF_EN
    output logic [XLEN-1:0]  io_out_rs2_data,
    output logic [31:0]      io_perf_stall_cycles,
    output logic [31:0]      io_perf_kill_count
`else
    output logic [XLEN-1:0]  io_out_rs2_data
`endif
);

    rrd_slot_t slot0_q, slot1_q;
    rrd_slot_t slot0_d, slot1_d;
    rrd_slot_t in_cur, in_upd, s0_upd, s1_upd;
    logic      deq, enq, s0_keep;

    // Incoming uop viewed as a slot so it gets the same resolve / kill treatment.
    always_comb begin
        in_cur.valid   = io_in_valid;
        in_cur.uop     = io_in_uop;
        in_cur.br_mask = io_in_br_mask;
        in_cur.rs1     = io_in_rs1_data;
        in_cur.rs2     = io_in_rs2_data;
    end

    rrd_slot_update u_upd_in (
        .cur             (in_cur),
        .resolve_mask    (io_brupdate_resolve_mask),
        .mispredict_mask (io_brupdate_mispredict_mask),
        .kill            (io_kill),
        .upd             (in_upd)
    );

    rrd_slot_update u_upd_s0 (
        .cur             (slot0_q),
        .resolve_mask    (io_brupdate_resolve_mask),
        .mispredict_mask (io_brupdate_mispredict_mask),
        .kill            (io_kill),
        .upd             (s0_upd)
    );

    rrd_slot_update u_upd_s1 (
        .cur             (slot1_q),
        .resolve_mask    (io_brupdate_resolve_mask),
        .mispredict_mask (io_brupdate_mispredict_mask),
        .kill            (io_kill),
        .upd             (s1_upd)
    );

    // Head presentation: a killed head is hidden, resolved bits cleared on the way out.
    always_comb begin
        io_in_ready     = ~slot1_q.valid;
        io_out_valid    = s0_upd.valid;
        io_out_uop      = slot0_q.uop;
        io_out_br_mask  = s0_upd.br_mask;
        io_out_rs1_data = slot0_q.rs1;
        io_out_rs2_data = slot0_q.rs2;
    end

    // Next state: drop killed / dequeued, compact slot1 down, then enqueue into lowest free slot.
    always_comb begin
        deq     = s0_upd.valid & io_out_ready;
        enq     = in_upd.valid & io_in_ready;
        s0_keep = s0_upd.valid & ~deq;
        slot0_d = s0_upd;
        slot1_d = s1_upd;
        if (s0_keep) begin
            // slot1 can only be free here if enq is allowed; full buffer never enqueues.
            if (!s1_upd.valid) begin
                slot1_d       = in_upd;
                slot1_d.valid = enq;
            end
        end else if (s1_upd.valid) begin
            slot0_d       = s1_upd;
            slot1_d       = in_upd;
            slot1_d.valid = enq;
        end else begin
            slot0_d       = in_upd;
            slot0_d.valid = enq;
            slot1_d.valid = 1'b0;
        end
    end

    // Slot registers; asynchronous reset empties the buffer immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

`ifdef RRD_EXE_SKID_BUFFER_PERF_EN
    logic [31:0] stall_q, kills_q;
    logic [1:0]  kill_inc;
    logic [32:0] stall_sum, kills_sum;

    // A stored slot was dropped by flush/mispredict when it was valid but its update is not.
    always_comb begin
        kill_inc  = {1'b0, slot0_q.valid & ~s0_upd.valid}
                  + {1'b0, slot1_q.valid & ~s1_upd.valid};
        stall_sum = {1'b0, stall_q} + {32'd0, io_out_valid & ~io_out_ready};
        kills_sum = {1'b0, kills_q} + {31'd0, kill_inc};
    end

    // Saturating performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            kills_q <= '0;
        end else begin
            stall_q <= stall_sum[32] ? 32'hFFFF_FFFF : stall_sum[31:0];
            kills_q <= kills_sum[32] ? 32'hFFFF_FFFF : kills_sum[31:0];
        end
    end

    assign io_perf_stall_cycles = stall_q;
    assign io_perf_kill_count   = kills_q;
`endif

endmodule

// File: tb/tb_rrd_exe_skid_buffer.sv
// Randomized self-checking bench for rrd_exe_skid_buffer against a queue-based model.
module tb_rrd_exe_skid_buffer;
    import rrd_pipe_pkg::*;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_in_valid = 1'b0;
    logic             io_in_ready;
    logic [UOP_W-1:0] io_in_uop = '0;
    logic [BR_W-1:0]  io_in_br_mask = '0;
    logic [XLEN-1:0]  io_in_rs1_data = '0;
    logic [XLEN-1:0]  io_in_rs2_data = '0;
    logic [BR_W-1:0]  io_brupdate_resolve_mask = '0;
    logic [BR_W-1:0]  io_brupdate_mispredict_mask = '0;
    logic             io_kill = 1'b0;
    logic             io_out_valid;
    logic             io_out_ready = 1'b0;
    logic [UOP_W-1:0] io_out_uop;
    logic [BR_W-1:0]  io_out_br_mask;
    logic [XLEN-1:0]  io_out_rs1_data;
    logic [XLEN-1:0]  io_out_rs2_data;
`ifdef RRD_EXE_SKID_BUFFER_PERF_EN
    logic [31:0]      io_perf_stall_cycles;
    logic [31:0]      io_perf_kill_count;
`endif

    rrd_exe_skid_buffer dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_in_valid                 (io_in_valid),
        .io_in_ready                 (io_in_ready),
        .io_in_uop                   (io_in_uop),
        .io_in_br_mask               (io_in_br_mask),
        .io_in_rs1_data              (io_in_rs1_data),
        .io_in_rs2_data              (io_in_rs2_data),
        .io_brupdate_resolve_mask    (io_brupdate_resolve_mask),
        .io_brupdate_mispredict_mask (io_brupdate_mispredict_mask),
        .io_kill                     (io_kill),
        .io_out_valid                (io_out_valid),
        .io_out_ready                (io_out_ready),
        .io_out_uop                  (io_out_uop),
        .io_out_br_mask              (io_out_br_mask),
        .io_out_rs1_data             (io_out_rs1_data),
`ifdef RRD_EXE_SKID_BUFFER_PERF_EN
        .io_out_rs2_data             (io_out_rs2_data),
        .io_perf_stall_cycles        (io_perf_stall_cycles),
        .io_perf_kill_count          (io_perf_kill_count)
`else
        .io_out_rs2_data             (io_out_rs2_data)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [UOP_W-1:0] uop;
        logic [BR_W-1:0]  mask;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
    } ent_t;

    ent_t        q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] stall_m = 0;
    logic [31:0] kills_m = 0;

    task automatic check(input string tag, input logic [UOP_W-1:0] got,
                         input logic [UOP_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs, advance the model.
    task automatic step(input logic iv, input logic [UOP_W-1:0] u, input logic [BR_W-1:0] m,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [BR_W-1:0] res, input logic [BR_W-1:0] mp,
                        input logic kl, input logic ordy);
        ent_t nq[$];
        logic ov;
        logic hit;
        @(negedge clock);
        io_in_valid = iv; io_in_uop = u; io_in_br_mask = m;
        io_in_rs1_data = a; io_in_rs2_data = b;
        io_brupdate_resolve_mask = res; io_brupdate_mispredict_mask = mp;
        io_kill = kl; io_out_ready = ordy;
        #1;
        ov = (q.size() > 0) && !(kl || |(q[0].mask & mp));
        check("in_ready", io_in_ready, q.size() < 2);
        check("out_valid", io_out_valid, ov);
        if (ov) begin
            check("out_uop", io_out_uop, q[0].uop);
            check("out_br_mask", io_out_br_mask, q[0].mask & ~res);
            check("out_rs1", io_out_rs1_data, q[0].rs1);
            check("out_rs2", io_out_rs2_data, q[0].rs2);
        end
`ifdef RRD_EXE_SKID_BUFFER_PERF_EN
        check("perf_stall", io_perf_stall_cycles, stall_m);
        check("perf_kill", io_perf_kill_count, kills_m);
        if (ov && !ordy) stall_m++;
`endif
        for (int i = 0; i < q.size(); i++) begin
            hit = kl || |(q[i].mask & mp);
            if (hit) kills_m++;
            else if (!(i == 0 && ov && ordy))
                nq.push_back('{uop: q[i].uop, mask: q[i].mask & ~res, rs1: q[i].rs1, rs2: q[i].rs2});
        end
        if (iv && q.size() < 2 && !kl && !(|(m & mp)))
            nq.push_back('{uop: u, mask: m & ~res, rs1: a, rs2: b});
        q = nq;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, '0, '0, '0, '0, '0, 1'b0, ordy);
    endtask

    function automatic logic [UOP_W-1:0] ruop();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #12;
        check("reset_out_valid", io_out_valid, 1'b0);
        check("reset_in_ready", io_in_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        // Single uop, one-cycle latency.
        step(1'b1, 128'hA1, 20'h00001, 64'h5, 64'h6, '0, '0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: three back-to-back, only two accepted, then drain in order.
        step(1'b1, 128'hA, 20'h0, 64'h10, 64'h11, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'hB, 20'h0, 64'h20, 64'h21, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'hC, 20'h0, 64'h30, 64'h31, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'hC, 20'h0, 64'h30, 64'h31, '0, '0, 1'b0, 1'b1);
        step(1'b1, 128'hC, 20'h0, 64'h30, 64'h31, '0, '0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Resolve clears bits combinationally and in storage.
        step(1'b1, 128'hD, 20'h00011, 64'h1, 64'h2, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, '0, '0, 20'h00001, '0, 1'b0, 1'b0);
        idle(1'b1);

        // Mispredict hits slot0 only; slot1 compacts, matching input dropped.
        step(1'b1, 128'hE, 20'h4, 64'h3, 64'h4, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'hF, 20'h0, 64'h5, 64'h6, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'h99, 20'h4, 64'h7, 64'h8, '0, 20'h4, 1'b0, 1'b0);
        step(1'b1, 128'h98, 20'h4, 64'h7, 64'h8, 20'h4, 20'h4, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Kill with a full buffer and a valid input.
        step(1'b1, 128'h11, 20'h0, 64'h1, 64'h1, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'h12, 20'h0, 64'h2, 64'h2, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'h13, 20'h0, 64'h3, 64'h3, '0, '0, 1'b1, 1'b1);
        idle(1'b1);

        // Async reset between edges with two valid entries.
        step(1'b1, 128'h21, 20'h0, 64'h1, 64'h1, '0, '0, 1'b0, 1'b0);
        step(1'b1, 128'h22, 20'h0, 64'h2, 64'h2, '0, '0, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge clock);
        io_in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_out_valid", io_out_valid, 1'b0);
        check("async_rst_in_ready", io_in_ready, 1'b1);
        q.delete();
        stall_m = 0;
        kills_m = 0;
        @(negedge clock);
        #2 reset = 1'b0;
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic; small mask space so mispredicts hit often.
        for (int n = 0; n < 3000; n++) begin
            logic [BR_W-1:0] mp;
            mp = ($urandom_range(0, 7) == 0) ? (BR_W'(1) << $urandom_range(0, 3)) : '0;
            step($urandom_range(0, 9) < 7, ruop(), BR_W'($urandom_range(0, 15)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 BR_W'($urandom_range(0, 15)) & BR_W'({4{$urandom_range(0, 3) == 0}}),
                 mp, $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
